gcd_engine: RTL and testbench

Parametrised, self-sequenced Euclidean GCD engine. Replaces the externally-sequenced 16-bit datapath plus controller pair with one block that owns its FSM, operand registers and an iterative shift-subtract modulo unit. It sits between the operand-input interface and the result display/check logic and is started by a one-cycle request.

---
 rtl/gcd_pkg.sv | 17 +
 rtl/gcd_mod_unit.sv | 75 +++++++
 rtl/gcd_engine.sv | 173 +++++++++++++++++
 tb/tb_gcd_engine.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the Euclidean GCD engine.
package gcd_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    MOD,
    DONE
  } state_t;

  function automatic int iter_w(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/gcd_mod_unit.sv
// Iterative restoring a mod b: one shift-subtract step per clock.
module gcd_mod_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic             ready_q;

  logic [WIDTH:0]   r_sh;
  logic             r_ge;
  logic [WIDTH-1:0] r_nxt;

  // The shifted remainder needs one extra bit; after a
  // subtract it always fits back into WIDTH bits.
  always_comb begin
    r_sh  = {r_q, q_q[WIDTH-1]};
    r_ge  = r_sh >= {1'b0, d_q};
    r_nxt = r_sh[WIDTH-1:0];
    if (r_ge) begin
      r_nxt = r_sh[WIDTH-1:0] - d_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      ready_q <= 1'b0;
    end else if (cancel_i) begin
      run_q   <= 1'b0;
      ready_q <= 1'b0;
    end else if (start_i) begin
      r_q     <= '0;
      q_q     <= dividend_i;
      d_q     <= divisor_i;
      cnt_q   <= CW'(WIDTH);
      run_q   <= 1'b1;
      ready_q <= 1'b0;
    end else if (run_q) begin
      r_q   <= r_nxt;
      q_q   <= {q_q[WIDTH-2:0], 1'b0};
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        run_q   <= 1'b0;
        ready_q <= 1'b1;
      end
    end else begin
      ready_q <= 1'b0;
    end
  end

  assign ready_o = ready_q;
  assign rem_o   = r_q;

endmodule

// File: rtl/gcd_engine.sv
// Self-sequenced Euclidean GCD: FSM, operand regs and held results.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_ITER = 2 * WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        clear_i,
  input  logic [WIDTH-1:0]            Zahl1_i,
  input  logic [WIDTH-1:0]            Zahl2_i,
  output logic                        busy_o,
  output logic                        valid_o,
  output logic [WIDTH-1:0]            ergebnis_o,
  output logic [iter_w(MAX_ITER)-1:0] iter_o,
  output logic                        zero_o,
  output logic                        err_o
);

  localparam int IW = iter_w(MAX_ITER);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    iter_q;
  logic [WIDTH-1:0] res_q;
  logic [IW-1:0]    iter_o_q;
  logic             zero_q;
  logic             err_q;

  logic             b_zero;
  logic             iter_max;
  logic             mod_start;
  logic             mod_ready;
  logic [WIDTH-1:0] mod_rem;
  logic             z1_ge;

  assign b_zero   = (b_q == '0);
  assign iter_max = (iter_q == IW'(MAX_ITER));
  assign z1_ge    = (Zahl1_i >= Zahl2_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (b_zero || iter_max) begin
          state_d = DONE;
        end else begin
          state_d = MOD;
        end
      end
      MOD: begin
        if (mod_ready) begin
          state_d = CHECK;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (clear_i) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    busy_o    = 1'b0;
    valid_o   = 1'b0;
    mod_start = 1'b0;
    unique case (state_q)
      CHECK: begin
        busy_o    = 1'b1;
        mod_start = !b_zero && !iter_max;
      end
      MOD: begin
        busy_o = 1'b1;
      end
      DONE: begin
        valid_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // Held results change only on an accepted start or entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      iter_q   <= '0;
      res_q    <= '0;
      iter_o_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (!clear_i) begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q      <= z1_ge ? Zahl1_i : Zahl2_i;
            b_q      <= z1_ge ? Zahl2_i : Zahl1_i;
            iter_q   <= '0;
            res_q    <= '0;
            iter_o_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        CHECK: begin
          if (b_zero) begin
            res_q    <= a_q;
            zero_q   <= (a_q == '0);
            iter_o_q <= iter_q;
          end else if (iter_max) begin
            res_q    <= '0;
            err_q    <= 1'b1;
            iter_o_q <= iter_q;
          end
        end
        MOD: begin
          if (mod_ready) begin
            a_q    <= b_q;
            b_q    <= mod_rem;
            iter_q <= iter_q + 1'b1;
          end
        end
        default: begin
          a_q <= a_q;
        end
      endcase
    end
  end

  gcd_mod_unit #(
    .WIDTH(WIDTH)
  ) u_mod (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mod_start),
    .cancel_i  (clear_i),
    .dividend_i(a_q),
    .divisor_i (b_q),
    .ready_o   (mod_ready),
    .rem_o     (mod_rem)
  );

  assign ergebnis_o = res_q;
  assign iter_o     = iter_o_q;
  assign zero_o     = zero_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: 16-bit, MAX_ITER=5 and 8-bit instances.
module tb_gcd_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_i = 1'b0;
  logic s16 = 1'b0;
  logic s5 = 1'b0;
  logic s8 = 1'b0;
  logic [15:0] z1 = '0;
  logic [15:0] z2 = '0;

  logic b16, v16, zr16, er16;
  logic [15:0] r16;
  logic [5:0] i16;
  logic b5, v5, zr5, er5;
  logic [15:0] r5;
  logic [2:0] i5;
  logic b8, v8, zr8, er8;
  logic [7:0] r8;
  logic [4:0] i8;

  int total = 0;
  int bad = 0;
  int sel = 0;

  logic o_busy, o_valid, o_zero, o_err;
  logic [15:0] o_res;
  logic [5:0] o_iter;

  always #5 clk = ~clk;

  gcd_engine dut16 (
    .clk(clk), .rst(rst), .start_i(s16), .clear_i(clear_i),
    .Zahl1_i(z1), .Zahl2_i(z2), .busy_o(b16), .valid_o(v16),
    .ergebnis_o(r16), .iter_o(i16), .zero_o(zr16), .err_o(er16)
  );

  gcd_engine #(.WIDTH(16), .MAX_ITER(5)) dut5 (
    .clk(clk), .rst(rst), .start_i(s5), .clear_i(clear_i),
    .Zahl1_i(z1), .Zahl2_i(z2), .busy_o(b5), .valid_o(v5),
    .ergebnis_o(r5), .iter_o(i5), .zero_o(zr5), .err_o(er5)
  );

  gcd_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(s8), .clear_i(clear_i),
    .Zahl1_i(z1[7:0]), .Zahl2_i(z2[7:0]), .busy_o(b8),
    .valid_o(v8), .ergebnis_o(r8), .iter_o(i8), .zero_o(zr8),
    .err_o(er8)
  );

  always_comb begin
    o_busy  = b16;
    o_valid = v16;
    o_res   = r16;
    o_iter  = i16;
    o_zero  = zr16;
    o_err   = er16;
    case (sel)
      1: begin
        o_busy  = b5;
        o_valid = v5;
        o_res   = r5;
        o_iter  = {3'b0, i5};
        o_zero  = zr5;
        o_err   = er5;
      end
      2: begin
        o_busy  = b8;
        o_valid = v8;
        o_res   = {8'b0, r8};
        o_iter  = {1'b0, i8};
        o_zero  = zr8;
        o_err   = er8;
      end
      default: begin
        o_busy = b16;
      end
    endcase
  end

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int lat;
  int busy_low;

  task automatic go(input int s, input logic [15:0] a,
                    input logic [15:0] b);
    @(negedge clk);
    sel = s;
    z1 = a;
    z2 = b;
    s16 = (s == 0);
    s5  = (s == 1);
    s8  = (s == 2);
    @(negedge clk);
    s16 = 1'b0;
    s5  = 1'b0;
    s8  = 1'b0;
    lat = 0;
    busy_low = 0;
    while (!o_valid && lat < 1000) begin
      if (lat >= 1 && !o_busy) busy_low++;
      @(negedge clk);
      lat++;
    end
    if (!o_valid) lat = -1;
  endtask

  task automatic res(input string tag, input int e_res,
                     input int e_iter, input int e_zero,
                     input int e_err, input int e_lat);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_res"}, o_res, e_res);
    chk({tag, "_iter"}, o_iter, e_iter);
    chk({tag, "_zero"}, o_zero, e_zero);
    chk({tag, "_err"}, o_err, e_err);
    chk({tag, "_busydone"}, o_busy, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, o_valid, 0);
    chk({tag, "_hold"}, o_res, e_res);
  endtask

  int seen;
  int last;
  int pulses;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_res", o_res, 0);
    chk("rst_iter", o_iter, 0);
    chk("rst_zero", o_zero, 0);
    chk("rst_err", o_err, 0);
    rst = 1'b0;

    // k iterations: valid seen k*18+1 cycles after start edge
    go(0, 16'd48, 16'd18);
    chk("g48_busylow", busy_low, 0);
    res("g48", 6, 3, 0, 0, 55);
    go(0, 16'd18, 16'd48);
    res("g18", 6, 3, 0, 0, 55);
    go(0, 16'd0, 16'd7);
    res("g07", 7, 0, 0, 0, 1);
    go(0, 16'd0, 16'd0);
    res("g00", 0, 0, 1, 0, 1);
    go(0, 16'd65535, 16'd65535);
    res("gmax", 65535, 1, 0, 0, 19);
    go(0, 16'd46368, 16'd28657);
    res("fib", 1, 22, 0, 0, 397);
    go(1, 16'd46368, 16'd28657);
    res("fib5", 0, 5, 0, 1, 91);

    // reset in the middle of a modulo run
    sel = 0;
    @(negedge clk);
    z1 = 16'd48;
    z2 = 16'd18;
    s16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    chk("rstmid_valid", seen, 0);
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_res", o_res, 0);
    go(0, 16'd12, 16'd8);
    res("g128a", 4, 2, 0, 0, 37);

    // clear in the middle of a modulo run
    @(negedge clk);
    z1 = 16'd48;
    z2 = 16'd18;
    s16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0;
    repeat (30) @(negedge clk);
    chk("clr_busybefore", o_busy, 1);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    chk("clr_valid", seen, 0);
    chk("clr_busy", o_busy, 0);
    chk("clr_res", o_res, 0);
    go(0, 16'd12, 16'd8);
    res("g128b", 4, 2, 0, 0, 37);

    // start held high: a new request every 2*10+1+2 cycles
    @(negedge clk);
    sel = 2;
    z1 = 16'd200;
    z2 = 16'd150;
    s8 = 1'b1;
    last = -1;
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (o_valid) begin
        chk("cont_res", o_res, 50);
        chk("cont_iter", o_iter, 2);
        if (last >= 0) chk("cont_gap", c - last, 23);
        else chk("cont_first", c, 21);
        last = c;
        pulses++;
      end
    end
    s8 = 1'b0;
    chk("cont_pulses", pulses, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
